// File: rtl/sram_ctr_ahb_protocol_checker.sv
// rtl/sram_ctr_ahb_protocol_checker.sv - registered AHB-Lite slave-side protocol checker
// Purpose: checks every accepted address phase (state, size, alignment, range,
//   SEQ address continuity, control stability, beat overrun), drives the
//   two-cycle ERROR response and keeps the last error cause/address plus a
//   saturating error count.
// Ports:
//   hclk, hreset            clock, synchronous active-high reset
//   hsel, hready_in         address phase accepted when both are high
//   htrans, hburst, hsize,
//   hwrite, haddr           AHB address-phase controls
//   hreadyout, hresp        registered slave response
//   err_valid               one-cycle pulse during the first ERROR cycle
//   err_code, err_addr      cause and haddr of the last error
//   err_cnt                 saturating error count
module sram_ctr_ahb_protocol_checker #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_AW       = 14,
  parameter bit ALLOW_NARROW = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic              hready_in,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  output logic              hreadyout,
  output logic              hresp,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int              MAX_SIZE   = $clog2(DATA_W / 8);
  localparam logic [2:0]      MAX_SIZE_L = 3'(MAX_SIZE);
  localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3,
                         B_WRAP8 = 3'd4, B_INCR8 = 3'd5, B_WRAP16 = 3'd6, B_INCR16 = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR1, S_ERR2} state_t;

  state_t            state_q, state_d;
  logic              hreadyout_q, hresp_q, err_valid_q;
  logic [2:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [2:0]        bsize_q, bsize_d, bburst_q, bburst_d;
  logic              bwrite_q, bwrite_d;
  logic              fixed_q, fixed_d;
  // Set when a fixed-length burst has delivered all its beats; a SEQ that
  // follows directly is an overrun rather than a plain out-of-state SEQ.
  logic              done_q, done_d;
  logic [3:0]        beats_left_q, beats_left_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;

  function automatic logic [3:0] beats_m1(input logic [2:0] burst);
    case (burst)
      B_WRAP4, B_INCR4:   beats_m1 = 4'd3;
      B_WRAP8, B_INCR8:   beats_m1 = 4'd7;
      B_WRAP16, B_INCR16: beats_m1 = 4'd15;
      default:            beats_m1 = 4'd0;
    endcase
  endfunction

  // Wrapping bursts increment only the low log2(beats)+size bits.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size,
                                                  input logic [2:0] burst);
    logic [ADDR_W-1:0] stp, inc, wmask;
    stp = ONE_A << size;
    inc = a + stp;
    case (burst)
      B_WRAP4:  wmask = (stp << 2) - ONE_A;
      B_WRAP8:  wmask = (stp << 3) - ONE_A;
      B_WRAP16: wmask = (stp << 4) - ONE_A;
      default:  wmask = '0;
    endcase
    next_addr = (wmask == '0) ? inc : ((a & ~wmask) | (inc & wmask));
  endfunction

  logic              acc, is_seq, is_busy, is_nonseq, in_idle, in_burst;
  logic              size_err, incr_fixed, range_hi;
  logic [MEM_AW:0]   last_beat;
  logic              chk_state, chk_size, chk_align, chk_range;
  logic              chk_seqaddr, chk_ctrl, chk_overrun;
  logic [2:0]        code;

  assign acc        = hsel & hready_in;
  assign is_seq     = (htrans == T_SEQ);
  assign is_busy    = (htrans == T_BUSY);
  assign is_nonseq  = (htrans == T_NONSEQ);
  assign in_idle    = (state_q == S_IDLE);
  assign in_burst   = (state_q == S_BURST);
  assign size_err   = (hsize > MAX_SIZE_L) || (!ALLOW_NARROW && (hsize != MAX_SIZE_L));
  assign incr_fixed = (hburst == B_INCR4) || (hburst == B_INCR8) || (hburst == B_INCR16);
  assign range_hi   = ((haddr >> MEM_AW) != '0);
  assign last_beat  = {1'b0, haddr[MEM_AW-1:0]}
                    + ({{(MEM_AW-3){1'b0}}, beats_m1(hburst)} << hsize);

  assign chk_state   = in_idle && (is_busy || (is_seq && !done_q));
  assign chk_size    = is_nonseq && size_err;
  assign chk_align   = is_nonseq && ((haddr & ~({ADDR_W{1'b1}} << hsize)) != '0);
  assign chk_range   = is_nonseq && (range_hi || (incr_fixed && last_beat[MEM_AW]));
  assign chk_seqaddr = is_seq && in_burst && (haddr != exp_addr_q);
  assign chk_ctrl    = is_seq && in_burst &&
                       ((hsize != bsize_q) || (hwrite != bwrite_q) || (hburst != bburst_q));
  assign chk_overrun = is_seq && in_idle && done_q;

  always_comb begin
    if      (chk_state)   code = 3'd1;
    else if (chk_size)    code = 3'd2;
    else if (chk_align)   code = 3'd3;
    else if (chk_range)   code = 3'd4;
    else if (chk_seqaddr) code = 3'd5;
    else if (chk_ctrl)    code = 3'd6;
    else if (chk_overrun) code = 3'd7;
    else                  code = 3'd0;
  end

  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    err_addr_d   = err_addr_q;
    err_cnt_d    = err_cnt_q;
    bsize_d      = bsize_q;
    bburst_d     = bburst_q;
    bwrite_d     = bwrite_q;
    fixed_d      = fixed_q;
    done_d       = done_q;
    beats_left_d = beats_left_q;
    exp_addr_d   = exp_addr_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (acc) begin
      if (code != 3'd0) begin
        state_d      = S_ERR1;
        err_code_d   = code;
        err_addr_d   = haddr;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        fixed_d      = 1'b0;
        done_d       = 1'b0;
        beats_left_d = 4'd0;
      end else begin
        case (htrans)
          T_NONSEQ: begin
            bsize_d      = hsize;
            bburst_d     = hburst;
            bwrite_d     = hwrite;
            fixed_d      = (hburst != B_INCR);
            beats_left_d = beats_m1(hburst);
            exp_addr_d   = next_addr(haddr, hsize, hburst);
            done_d       = (hburst == B_SINGLE);
            state_d      = (hburst == B_SINGLE) ? S_IDLE : S_BURST;
          end
          T_SEQ, T_BUSY: begin
            // In ERR2 the master is cancelling the burst: ignore and settle.
            if (state_q == S_ERR2) begin
              state_d = S_IDLE;
            end else if (is_seq) begin
              exp_addr_d = next_addr(exp_addr_q, bsize_q, bburst_q);
              if (fixed_q) begin
                beats_left_d = beats_left_q - 4'd1;
                if (beats_left_q == 4'd1) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
              end
            end
          end
          default: begin
            // IDLE ends any burst, including early termination of a fixed one.
            state_d = S_IDLE;
            done_d  = 1'b0;
          end
        endcase
      end
    end else if (state_q == S_ERR2) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= S_IDLE;
      hreadyout_q  <= 1'b1;
      hresp_q      <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= 3'd0;
      err_addr_q   <= '0;
      err_cnt_q    <= '0;
      bsize_q      <= 3'd0;
      bburst_q     <= 3'd0;
      bwrite_q     <= 1'b0;
      fixed_q      <= 1'b0;
      done_q       <= 1'b0;
      beats_left_q <= 4'd0;
      exp_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      hreadyout_q  <= (state_d != S_ERR1);
      hresp_q      <= (state_d == S_ERR1) || (state_d == S_ERR2);
      err_valid_q  <= (state_d == S_ERR1);
      err_code_q   <= err_code_d;
      err_addr_q   <= err_addr_d;
      err_cnt_q    <= err_cnt_d;
      bsize_q      <= bsize_d;
      bburst_q     <= bburst_d;
      bwrite_q     <= bwrite_d;
      fixed_q      <= fixed_d;
      done_q       <= done_d;
      beats_left_q <= beats_left_d;
      exp_addr_q   <= exp_addr_d;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule
